// File: rtl/elevator_request_queue.sv
// Elevator request queue: merges hall/cab presses, dedups per floor, queues floors FIFO.
// Optional input debounce is enabled by defining REQ_DEBOUNCE_EN.
module elevator_request_queue #(
    parameter int NUM_FLOORS      = 5,
    parameter int FLOOR_W         = 3,
    parameter int DEPTH           = 8,
    parameter int PTR_W           = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] request_buttons,
    input  logic [NUM_FLOORS-1:0] elevator_buttons,
    input  logic                  served_valid,
    input  logic [FLOOR_W-1:0]    served_floor,
    output logic                  req_valid,
    output logic [FLOOR_W-1:0]    req_floor,
    input  logic                  req_ready,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [PTR_W:0]        count,
    output logic                  full
);

    localparam int FLOOR_SPAN = 1 << FLOOR_W;

    if ((FLOOR_SPAN < NUM_FLOORS) || (DEPTH < NUM_FLOORS) || ((1 << PTR_W) != DEPTH)
        || (DEBOUNCE_CYCLES < 1)) begin : g_bad_params
        $error("elevator_request_queue: inconsistent parameters");
    end

    logic [NUM_FLOORS-1:0] btn_raw;
    logic [NUM_FLOORS-1:0] btn_lvl;
    logic [NUM_FLOORS-1:0] hist_q, hist_d;
    logic [NUM_FLOORS-1:0] latch_q, latch_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] served_mask, new_press, push_mask;
    logic [FLOOR_W-1:0]    fifo_q [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]        count_q, count_d;
    logic [FLOOR_SPAN-1:0] pend_ext;
    logic [FLOOR_W-1:0]    head_floor, push_floor;
    logic                  non_empty, head_live, full_w, pop, deq, push;

    assign btn_raw = request_buttons | elevator_buttons;

`ifdef REQ_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DB_W-1:0]       db_cnt_q [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] db_lvl_q;

    // Level flips on the DEBOUNCE_CYCLES-th consecutive sample that differs from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int f = 0; f < NUM_FLOORS; f++) db_cnt_q[f] <= '0;
            db_lvl_q <= '0;
        end else begin
            for (int f = 0; f < NUM_FLOORS; f++) begin
                if (btn_raw[f] == db_lvl_q[f]) begin
                    db_cnt_q[f] <= '0;
                end else if (db_cnt_q[f] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_lvl_q[f] <= btn_raw[f];
                    db_cnt_q[f] <= '0;
                end else begin
                    db_cnt_q[f] <= db_cnt_q[f] + 1'b1;
                end
            end
        end
    end

    assign btn_lvl = db_lvl_q;
`else
    assign btn_lvl = btn_raw;
`endif

    always_comb begin
        pend_ext = '0;
        pend_ext[NUM_FLOORS-1:0] = pending_q;
        head_floor = fifo_q[head_q];
        non_empty  = (count_q != '0);
        head_live  = pend_ext[head_floor];
        full_w     = (count_q == (PTR_W+1)'(DEPTH));
        req_valid  = non_empty && head_live;
        pop        = req_valid && req_ready;
        // A stale head (served en route) is dropped without a handshake.
        deq        = pop || (non_empty && !head_live);
    end

    always_comb begin
        served_mask = '0;
        push_floor  = '0;
        push_mask   = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            served_mask[f] = served_valid && (served_floor == FLOOR_W'(f));
        end
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (latch_q[f]) push_floor = FLOOR_W'(f);
        end
        push = (latch_q != '0) && (!full_w || deq);
        if (push) push_mask[push_floor] = 1'b1;
        // A press coinciding with a serve of the same floor wins.
        new_press = btn_lvl & ~hist_q & (~pending_q | served_mask);
        latch_d   = (latch_q & ~push_mask & ~served_mask) | new_press;
        pending_d = (pending_q & ~served_mask) | new_press;
        hist_d    = btn_lvl;
        head_d    = deq  ? head_q + 1'b1 : head_q;
        tail_d    = push ? tail_q + 1'b1 : tail_q;
        count_d   = count_q;
        if (push && !deq) count_d = count_q + 1'b1;
        if (deq && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q    <= '0;
            latch_q   <= '0;
            pending_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            hist_q    <= hist_d;
            latch_q   <= latch_d;
            pending_q <= pending_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) fifo_q[tail_q] <= push_floor;
    end

    assign req_floor = req_valid ? head_floor : '0;
    assign pending   = pending_q;
    assign count     = count_q;
    assign full      = full_w;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Bench for elevator_request_queue: directed scenarios then random traffic, all
// checked each cycle against a queue-based reference model.
module tb_elevator_request_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] request_buttons, elevator_buttons;
    logic       served_valid;
    logic [2:0] served_floor;
    logic       req_valid;
    logic [2:0] req_floor;
    logic       req_ready;
    logic [4:0] pending;
    logic [3:0] count;
    logic       full;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int         mq[$];
    logic [4:0] m_pend, m_latch, m_hist;

    elevator_request_queue dut (
        .clk              (clk),
        .reset            (reset),
        .request_buttons  (request_buttons),
        .elevator_buttons (elevator_buttons),
        .served_valid     (served_valid),
        .served_floor     (served_floor),
        .req_valid        (req_valid),
        .req_floor        (req_floor),
        .req_ready        (req_ready),
        .pending          (pending),
        .count            (count),
        .full             (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_valid();
        if (mq.size() == 0) return 1'b0;
        return m_pend[mq[0]];
    endfunction

    task automatic model_step(input logic rst, input logic [4:0] btn, input logic rdy,
                              input logic sv, input logic [2:0] sf);
        logic [4:0] smask, newp;
        logic       deq, push;
        int         pf;
        if (rst) begin
            mq.delete();
            m_pend = '0; m_latch = '0; m_hist = '0;
            return;
        end
        smask = '0;
        for (int f = 0; f < 5; f++) if (sv && sf == 3'(f)) smask[f] = 1'b1;
        deq  = (mq.size() != 0) && (!m_pend[mq[0]] || rdy);
        push = 1'b0;
        pf   = 0;
        for (int f = 4; f >= 0; f--) if (m_latch[f]) begin push = 1'b1; pf = f; end
        if (mq.size() >= 8 && !deq) push = 1'b0;
        newp = btn & ~m_hist & (~m_pend | smask);
        if (deq) void'(mq.pop_front());
        if (push) begin
            mq.push_back(pf);
            m_latch[pf] = 1'b0;
        end
        m_latch = (m_latch & ~smask) | newp;
        m_pend  = (m_pend & ~smask) | newp;
        m_hist  = btn;
    endtask

    task automatic check_model();
        logic       ev;
        logic [2:0] ef;
        ev = m_valid();
        ef = ev ? 3'(mq[0]) : 3'd0;
        check("model_req_valid", {7'd0, req_valid}, {7'd0, ev});
        check("model_req_floor", {5'd0, req_floor}, {5'd0, ef});
        check("model_pending",   {3'd0, pending},   {3'd0, m_pend});
        check("model_count",     {4'd0, count},     8'(mq.size()));
        check("model_full",      {7'd0, full},      {7'd0, mq.size() == 8});
    endtask

    task automatic step(input logic rst, input logic [4:0] rb, input logic [4:0] eb,
                        input logic rdy, input logic sv, input logic [2:0] sf);
        reset            = rst;
        request_buttons  = rb;
        elevator_buttons = eb;
        req_ready        = rdy;
        served_valid     = sv;
        served_floor     = sf;
        @(posedge clk);
        model_step(rst, rb | eb, rdy, sv, sf);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, rdy, 1'b0, 3'd0);
    endtask

    initial begin
        model_step(1'b1, 5'd0, 1'b0, 1'b0, 3'd0);

        // reset state
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0);
        check("rst_req_valid", {7'd0, req_valid}, 8'd0);
        check("rst_req_floor", {5'd0, req_floor}, 8'd0);
        check("rst_pending",   {3'd0, pending},   8'd0);
        check("rst_count",     {4'd0, count},     8'd0);
        check("rst_full",      {7'd0, full},      8'd0);

        // single press latency and pop
        step(1'b0, 5'b01000, 5'd0, 1'b1, 1'b0, 3'd0);
        check("t1_pending", {3'd0, pending}, 8'b01000);
        check("t1_valid_early", {7'd0, req_valid}, 8'd0);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 3'd0);
        check("t1_valid", {7'd0, req_valid}, 8'd1);
        check("t1_floor", {5'd0, req_floor}, 8'd3);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 3'd0);
        check("t1_count_drain", {4'd0, count}, 8'd0);
        check("t1_pending_kept", {3'd0, pending}, 8'b01000);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 3'd3);
        check("t1_served", {3'd0, pending}, 8'd0);

        // simultaneous presses enqueue in ascending order
        step(1'b0, 5'b10000, 5'b00010, 1'b0, 1'b0, 3'd0);
        idle(2, 1'b0);
        check("t2_count", {4'd0, count}, 8'd2);
        check("t2_pending", {3'd0, pending}, 8'b10010);
        check("t2_head", {5'd0, req_floor}, 8'd1);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 3'd0);
        check("t2_second", {5'd0, req_floor}, 8'd4);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 3'd1);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 3'd4);
        idle(2, 1'b0);
        check("t2_clean", {4'd0, count}, 8'd0);

        // repeated presses deduplicate; serve re-arms
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'b00100, 5'd0, 1'b0, 1'b0, 3'd0);
            step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0);
        end
        check("t3_dedup", {4'd0, count}, 8'd1);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 3'd2);
        step(1'b0, 5'd0, 5'b00100, 1'b0, 1'b0, 3'd0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0);
        check("t3_requeue_count", {4'd0, count}, 8'd1);
        check("t3_requeue_floor", {5'd0, req_floor}, 8'd2);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 3'd2);
        idle(2, 1'b0);

        // stale head discarded silently
        step(1'b0, 5'b00100, 5'd0, 1'b0, 1'b0, 3'd0);
        step(1'b0, 5'b00001, 5'd0, 1'b0, 1'b0, 3'd0);
        idle(2, 1'b0);
        check("t4_count", {4'd0, count}, 8'd2);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 3'd2);
        check("t4_no_handshake", {7'd0, req_valid}, 8'd0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0);
        check("t4_floor0", {5'd0, req_floor}, 8'd0);
        check("t4_valid0", {7'd0, req_valid}, 8'd1);
        check("t4_count1", {4'd0, count}, 8'd1);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 3'd0);
        idle(2, 1'b0);

        // out-of-range serve is ignored
        step(1'b0, 5'b00001, 5'd0, 1'b0, 1'b0, 3'd0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 3'd6);
        check("oor_serve", {3'd0, pending}, 8'b00001);

        // fill to full; next press waits, pop+push keeps count at 8
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 5'b00010, 5'd0, 1'b0, 1'b0, 3'd0);
            step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0);
            if (i < 6) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 3'd1);
        end
        check("t5_full", {7'd0, full}, 8'd1);
        check("t5_count", {4'd0, count}, 8'd8);
        step(1'b0, 5'b00100, 5'd0, 1'b0, 1'b0, 3'd0);
        idle(2, 1'b0);
        check("t5_wait_count", {4'd0, count}, 8'd8);
        check("t5_wait_pending", {3'd0, pending}, 8'b00111);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 3'd0);
        check("t5_pop_push_count", {4'd0, count}, 8'd8);
        check("t5_pop_push_full", {7'd0, full}, 8'd1);

        // reset mid-operation with a held button
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0);
        step(1'b0, 5'd0, 5'b00111, 1'b0, 1'b0, 3'd0);
        idle(4, 1'b0);
        check("t6_count3", {4'd0, count}, 8'd3);
        step(1'b1, 5'b10000, 5'd0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 5'b10000, 5'd0, 1'b0, 1'b0, 3'd0);
        check("t6_rst_count", {4'd0, count}, 8'd0);
        check("t6_rst_pending", {3'd0, pending}, 8'd0);
        check("t6_rst_valid", {7'd0, req_valid}, 8'd0);
        step(1'b0, 5'b10000, 5'd0, 1'b0, 1'b0, 3'd0);
        step(1'b0, 5'b10000, 5'd0, 1'b0, 1'b0, 3'd0);
        check("t6_held_valid", {7'd0, req_valid}, 8'd1);
        check("t6_held_floor", {5'd0, req_floor}, 8'd4);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [4:0] rb, eb;
            rb = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
            eb = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            step($urandom_range(0, 199) == 0, rb, eb, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
